// File: rtl/rej_sampler.sv
// -----------------------------------------------------------------------------
// rej_sampler
//
// Kyber uniform rejection sampler (Parse). It takes the SHAKE128 squeeze
// stream from keccak as 64-bit words and stores the bytes in a 16-byte FIFO.
// On each SAMPLE cycle with at least three buffered bytes, it pops one 3-byte
// group and splits it into two 12-bit candidates:
//     d1 = {b1[3:0], b0}
//     d2 = {b2, b1[7:4]}
// A candidate is kept when it is below Q. Kept candidates go to the
// polynomial RAM, up to two per cycle, until N_COEF coefficients exist.
//
// Ports
//   i_clk           clock
//   i_rst           synchronous reset, active-high
//   i_start         pulse: begin a new polynomial (flush buffer, clear counter)
//   i_obytes        squeeze word; stream byte k = i_obytes[8k+7:8k]
//   i_obytes_valid  word valid
//   o_in_ready      word accepted when i_obytes_valid & o_in_ready
//   o_coef0         lane-0 coefficient, written at o_coef_addr
//   o_coef1         lane-1 coefficient, written at o_coef_addr+1
//   o_coef_wr_en    per-lane write enable (2'b10 never occurs)
//   o_coef_addr     RAM address of lane 0
//   o_done          one-cycle pulse after the final coefficient write
//   o_rej_cnt       (REJ_SAMPLER_STAT_EN only) rejected candidates since
//                   i_start, saturating at 1023
//
// Build option: define REJ_SAMPLER_STAT_EN to add the o_rej_cnt statistic.
// -----------------------------------------------------------------------------
module rej_sampler #(
    parameter int BW_DATA = 64,
    parameter int BW_COEF = 12,
    parameter int Q       = 3329,
    parameter int N_COEF  = 256
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [BW_DATA-1:0] i_obytes,
    input  logic               i_obytes_valid,
    output logic               o_in_ready,
    output logic [BW_COEF-1:0] o_coef0,
    output logic [BW_COEF-1:0] o_coef1,
    output logic [1:0]         o_coef_wr_en,
    output logic [7:0]         o_coef_addr,
`ifdef REJ_SAMPLER_STAT_EN
    output logic [9:0]         o_rej_cnt,
`endif
    output logic               o_done
);

    localparam int WORD_BYTES = BW_DATA / 8;
    localparam int BUF_BYTES  = 2 * WORD_BYTES;
    localparam logic [BW_COEF-1:0] Q_C      = BW_COEF'(Q);
    localparam logic [8:0]         LAST_IDX = 9'(N_COEF - 1);
    localparam logic [8:0]         FULL_CNT = 9'(N_COEF);

    typedef enum logic [1:0] {ST_IDLE, ST_SAMPLE, ST_DONE} state_t;

    state_t             state_reg;
    logic [7:0]         buf_reg  [BUF_BYTES];
    logic [7:0]         buf_next [BUF_BYTES];
    logic [7:0]         in_bytes [WORD_BYTES];
    logic [4:0]         count_reg, count_next, base;
    logic [8:0]         coef_cnt_reg, coef_cnt_next;
    logic               pop, accept, last_slot;
    logic [BW_COEF-1:0] d1, d2;
    logic               a1, a2;
    logic [1:0]         wr_next, n_wr;
    logic [BW_COEF-1:0] c0_next, c1_next;
    logic [BW_COEF-1:0] coef0_reg, coef1_reg;
    logic [1:0]         wr_en_reg;
    logic [7:0]         addr_reg;
    logic               done_reg;

    assign o_in_ready = (state_reg == ST_SAMPLE) && (count_reg <= 5'd8);
    // The word presented while i_start is high belongs to the old request.
    assign accept     = i_obytes_valid && o_in_ready && !i_start;
    assign pop        = (state_reg == ST_SAMPLE) && (count_reg >= 5'd3);
    // After the pop, this is where the incoming word lands in the FIFO.
    assign base       = pop ? (count_reg - 5'd3) : count_reg;
    assign count_next = base + (accept ? 5'd8 : 5'd0);

    generate
        for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_in_bytes
            assign in_bytes[gi] = i_obytes[8*gi +: 8];
        end

        // Each FIFO slot keeps its byte, takes the byte three places up on a
        // pop, or takes a byte from the incoming word behind the survivors.
        for (genvar gi = 0; gi < BUF_BYTES; gi++) begin : g_buf
            logic [7:0] kept;
            logic [4:0] rel;
            if (gi + 3 < BUF_BYTES) begin : g_shift
                assign kept = pop ? buf_reg[gi+3] : buf_reg[gi];
            end else begin : g_top
                assign kept = pop ? 8'h00 : buf_reg[gi];
            end
            // When gi < base, rel wraps to a large value, so rel < 8 alone
            // selects the eight slots that receive the new word.
            assign rel          = 5'(gi) - base;
            assign buf_next[gi] = (accept && (rel < 5'd8)) ? in_bytes[rel[2:0]] : kept;
        end
    endgenerate

    assign d1        = {buf_reg[1][3:0], buf_reg[0]};
    assign d2        = {buf_reg[2], buf_reg[1][7:4]};
    assign a1        = d1 < Q_C;
    assign a2        = d2 < Q_C;
    assign last_slot = (coef_cnt_reg == LAST_IDX);

    // Pack the accepted candidates onto the lanes, starting at lane 0.
    always_comb begin
        wr_next = 2'b00;
        n_wr    = 2'd0;
        c0_next = d1;
        c1_next = d2;
        if (pop) begin
            case ({a1, a2})
                2'b11: begin
                    // Only one slot is left, so d2 is dropped.
                    wr_next = last_slot ? 2'b01 : 2'b11;
                    n_wr    = last_slot ? 2'd1 : 2'd2;
                end
                2'b10: begin
                    wr_next = 2'b01;
                    n_wr    = 2'd1;
                end
                2'b01: begin
                    wr_next = 2'b01;
                    n_wr    = 2'd1;
                    c0_next = d2;
                end
                default: ;
            endcase
        end
    end

    assign coef_cnt_next = coef_cnt_reg + 9'(n_wr);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= ST_IDLE;
            count_reg    <= '0;
            coef_cnt_reg <= '0;
            coef0_reg    <= '0;
            coef1_reg    <= '0;
            wr_en_reg    <= 2'b00;
            addr_reg     <= '0;
            done_reg     <= 1'b0;
        end else if (i_start) begin
            state_reg    <= ST_SAMPLE;
            count_reg    <= '0;
            coef_cnt_reg <= '0;
            wr_en_reg    <= 2'b00;
            done_reg     <= 1'b0;
        end else begin
            wr_en_reg <= 2'b00;
            done_reg  <= 1'b0;
            case (state_reg)
                ST_SAMPLE: begin
                    for (int i = 0; i < BUF_BYTES; i++) begin
                        buf_reg[i] <= buf_next[i];
                    end
                    count_reg    <= count_next;
                    wr_en_reg    <= wr_next;
                    coef0_reg    <= c0_next;
                    coef1_reg    <= c1_next;
                    addr_reg     <= coef_cnt_reg[7:0];
                    coef_cnt_reg <= coef_cnt_next;
                    if (coef_cnt_next == FULL_CNT) begin
                        state_reg <= ST_DONE;
                        count_reg <= '0;   // leftover bytes are discarded
                    end
                end
                ST_DONE: begin
                    done_reg  <= 1'b1;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign o_coef0      = coef0_reg;
    assign o_coef1      = coef1_reg;
    assign o_coef_wr_en = wr_en_reg;
    assign o_coef_addr  = addr_reg;
    assign o_done       = done_reg;

`ifdef REJ_SAMPLER_STAT_EN
    logic [1:0]  rej_inc;
    logic [10:0] rej_sum;
    logic [9:0]  rej_cnt_reg;

    // A d2 that is accepted but dropped at the last slot counts as rejected.
    always_comb begin
        rej_inc = 2'd0;
        if (pop) begin
            rej_inc = 2'({1'b0, ~a1}) + 2'({1'b0, ~a2}) + 2'({1'b0, a1 & a2 & last_slot});
        end
    end

    assign rej_sum = {1'b0, rej_cnt_reg} + 11'(rej_inc);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_start) begin
            rej_cnt_reg <= '0;
        end else if (state_reg == ST_SAMPLE) begin
            rej_cnt_reg <= (rej_sum > 11'd1023) ? 10'd1023 : rej_sum[9:0];
        end
    end

    assign o_rej_cnt = rej_cnt_reg;
`endif

endmodule

// File: tb/tb_rej_sampler.sv
// -----------------------------------------------------------------------------
// tb_rej_sampler
//
// Self-checking bench for rej_sampler. Single-triple vectors come from a
// table. Hand-written sequences cover the address step, a mid-run reset, the
// 255-boundary and a restart. Whole polynomials come from random or fixed byte
// streams and are checked against a reference model that runs Parse directly
// on the byte stream.
// -----------------------------------------------------------------------------
module tb_rej_sampler;

    typedef byte unsigned bq_t[$];
    typedef int           iq_t[$];

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [63:0] i_obytes;
    logic        i_obytes_valid;
    logic        o_in_ready;
    logic [11:0] o_coef0, o_coef1;
    logic [1:0]  o_coef_wr_en;
    logic [7:0]  o_coef_addr;
    logic        o_done;
`ifdef REJ_SAMPLER_STAT_EN
    logic [9:0]  o_rej_cnt;
`endif

    rej_sampler dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_start        (i_start),
        .i_obytes       (i_obytes),
        .i_obytes_valid (i_obytes_valid),
        .o_in_ready     (o_in_ready),
        .o_coef0        (o_coef0),
        .o_coef1        (o_coef1),
        .o_coef_wr_en   (o_coef_wr_en),
        .o_coef_addr    (o_coef_addr),
`ifdef REJ_SAMPLER_STAT_EN
        .o_rej_cnt      (o_rej_cnt),
`endif
        .o_done         (o_done)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- write monitor ----------------
    int cyc = 0;
    int wr_addr_q[$];
    int wr_data_q[$];
    int last_wr_cyc = 0;
    int last_wr_en  = 0;
    int done_cnt    = 0;
    int done_cyc    = 0;

    always @(posedge i_clk) cyc++;

    always @(negedge i_clk) begin
        if (o_coef_wr_en != 2'b00) begin
            check("wr_en_not_10", int'(o_coef_wr_en == 2'b10), 0);
            if (o_coef_wr_en[0]) begin
                wr_addr_q.push_back(int'(o_coef_addr));
                wr_data_q.push_back(int'(o_coef0));
            end
            if (o_coef_wr_en[1]) begin
                wr_addr_q.push_back(int'(o_coef_addr) + 1);
                wr_data_q.push_back(int'(o_coef1));
            end
            last_wr_cyc = cyc;
            last_wr_en  = int'(o_coef_wr_en);
        end
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // ---------------- reference model ----------------
    // Parse rules applied directly to the byte stream.
    function automatic void model(input bq_t bs, output iq_t coefs, output int rej);
        coefs = {};
        rej   = 0;
        for (int i = 0; i + 2 < bs.size() && coefs.size() < 256; i += 3) begin
            int d1, d2;
            d1 = int'(bs[i]) + 256 * (int'(bs[i+1]) % 16);
            d2 = int'(bs[i+1]) / 16 + 16 * int'(bs[i+2]);
            if (d1 < 3329) coefs.push_back(d1); else rej++;
            if (d2 < 3329 && coefs.size() < 256) coefs.push_back(d2); else rej++;
        end
    endfunction

    function automatic logic [63:0] word_of(input bq_t bs, input int w);
        logic [63:0] v;
        for (int k = 0; k < 8; k++) v[8*k +: 8] = bs[8*w + k];
        return v;
    endfunction

    task automatic pulse_start();
        i_start        = 1'b1;
        i_obytes_valid = 1'b1;                 // must not be taken
        i_obytes       = {$urandom, $urandom};
        @(posedge i_clk); #1;
        i_start        = 1'b0;
        i_obytes_valid = 1'b0;
    endtask

    // Runs one full polynomial from byte stream bs and compares with the model.
    task automatic run_poly(input bq_t bs, input int valid_pct, input string name,
                            output int ready_low_seen);
        iq_t exp_c;
        int  exp_rej, n_words, idx, budget, nchk;
        bit  r;
        model(bs, exp_c, exp_rej);
        n_words = bs.size() / 8;
        pulse_start();
        wr_addr_q = {};
        wr_data_q = {};
        done_cnt  = 0;
`ifdef REJ_SAMPLER_STAT_EN
        check({name, "_rej_cleared"}, int'(o_rej_cnt), 0);
`endif
        ready_low_seen = 0;
        idx = 0;
        budget = 0;
        while (done_cnt == 0 && budget < 3000) begin
            if (idx < n_words) begin
                i_obytes_valid = ($urandom_range(0, 99) < valid_pct);
                i_obytes       = word_of(bs, idx);
            end else begin
                i_obytes_valid = 1'b0;
            end
            @(negedge i_clk);
            r = o_in_ready;
            if (i_obytes_valid && !r) ready_low_seen = 1;
            @(posedge i_clk);
            if (i_obytes_valid && r) idx++;
            #1;
            budget++;
        end
        i_obytes_valid = 1'b0;
        check({name, "_done_in_budget"}, int'(done_cnt > 0), 1);
        check({name, "_ready_after_done"}, int'(o_in_ready), 0);
        repeat (3) @(posedge i_clk);
        #1;
        check({name, "_done_pulses"}, done_cnt, 1);
        check({name, "_done_timing"}, done_cyc, last_wr_cyc + 1);
        check({name, "_ready_idle"}, int'(o_in_ready), 0);
        check({name, "_write_count"}, wr_addr_q.size(), exp_c.size());
        nchk = (wr_addr_q.size() < exp_c.size()) ? wr_addr_q.size() : exp_c.size();
        for (int i = 0; i < nchk; i++) begin
            check($sformatf("%s_addr[%0d]", name, i), wr_addr_q[i], i);
            check($sformatf("%s_coef[%0d]", name, i), wr_data_q[i], exp_c[i]);
        end
`ifdef REJ_SAMPLER_STAT_EN
        check({name, "_rej_cnt"}, int'(o_rej_cnt), (exp_rej > 1023) ? 1023 : exp_rej);
`endif
        $display("poly %s: %0d writes seen, %0d expected, %0d rejects expected",
                 name, wr_addr_q.size(), exp_c.size(), exp_rej);
    endtask

    // ---------------- single-triple table ----------------
    typedef struct {
        logic [7:0] b0, b1, b2;
        logic [1:0] wr;
        int         c0, c1;
    } vec_t;

    vec_t vecs[7];

    initial begin
        bq_t bs;
        int  rls, sz0, budget;

        vecs[0] = '{8'h01, 8'h23, 8'h45, 2'b11, 769, 1106};
        vecs[1] = '{8'hFF, 8'hFF, 8'hFF, 2'b00, 0, 0};
        vecs[2] = '{8'h01, 8'h0D, 8'h0D, 2'b01, 208, 0};   // 3329 rejected
        vecs[3] = '{8'h00, 8'hFD, 8'h00, 2'b11, 3328, 15}; // 3328 accepted
        vecs[4] = '{8'h00, 8'h00, 8'h00, 2'b11, 0, 0};
        vecs[5] = '{8'hFF, 8'h0F, 8'h00, 2'b01, 0, 0};     // d2 only -> lane 0
        vecs[6] = '{8'h05, 8'hD0, 8'hD0, 2'b01, 5, 0};     // d2=3341 rejected

        // Reset
        i_rst = 1'b1; i_start = 1'b0; i_obytes_valid = 1'b0; i_obytes = '0;
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_ready", int'(o_in_ready), 0);
        check("rst_wr_en", int'(o_coef_wr_en), 0);
        check("rst_done", int'(o_done), 0);
        check("rst_addr", int'(o_coef_addr), 0);
        i_rst = 1'b0;
        $display("reset: ready=%0d wr_en=%0d done=%0d", o_in_ready, o_coef_wr_en, o_done);

        // Table-driven single triples, padded with FF bytes (always rejected)
        for (int v = 0; v < 7; v++) begin
            pulse_start();
            i_obytes_valid = 1'b1;
            i_obytes       = {40'hFF_FFFF_FFFF, vecs[v].b2, vecs[v].b1, vecs[v].b0};
            @(posedge i_clk); #1;
            i_obytes_valid = 1'b0;
            @(posedge i_clk); #1;
            check($sformatf("vec%0d_wr_en", v), int'(o_coef_wr_en), int'(vecs[v].wr));
            check($sformatf("vec%0d_addr", v), int'(o_coef_addr), 0);
            if (vecs[v].wr[0]) check($sformatf("vec%0d_coef0", v), int'(o_coef0), vecs[v].c0);
            if (vecs[v].wr[1]) check($sformatf("vec%0d_coef1", v), int'(o_coef1), vecs[v].c1);
            @(posedge i_clk); #1;
            check($sformatf("vec%0d_filler_wr_en", v), int'(o_coef_wr_en), 0);
            $display("vec %0d: bytes %h %h %h -> wr_en=%b coef0=%0d coef1=%0d",
                     v, vecs[v].b0, vecs[v].b1, vecs[v].b2, o_coef_wr_en, o_coef0, o_coef1);
        end

        // Address advances by the number written
        pulse_start();
        i_obytes_valid = 1'b1;
        i_obytes       = 64'h0000_4523_0145_2301;
        @(posedge i_clk); #1;
        i_obytes_valid = 1'b0;
        @(posedge i_clk); #1;
        check("seq_addr_first", int'(o_coef_addr), 0);
        check("seq_wr_first", int'(o_coef_wr_en), 3);
        @(posedge i_clk); #1;
        check("seq_addr_second", int'(o_coef_addr), 2);
        check("seq_wr_second", int'(o_coef_wr_en), 3);
        check("seq_coef0_second", int'(o_coef0), 769);
        $display("seq addr step: second write at addr %0d", o_coef_addr);

        // Mid-run reset: no done, no further writes
        pulse_start();
        done_cnt = 0;
        i_obytes_valid = 1'b1;
        i_obytes = '0;
        repeat (3) @(posedge i_clk);
        #1;
        i_obytes_valid = 1'b0;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        check("midrst_ready", int'(o_in_ready), 0);
        check("midrst_wr_en", int'(o_coef_wr_en), 0);
        sz0 = wr_addr_q.size();
        repeat (4) @(posedge i_clk);
        #1;
        check("midrst_no_writes", wr_addr_q.size(), sz0);
        check("midrst_no_done", done_cnt, 0);
        $display("mid-run reset: done pulses %0d", done_cnt);

        // Random stream with continuous valid
        bs = {};
        for (int i = 0; i < 720; i++) bs.push_back(byte'($urandom_range(0, 255)));
        run_poly(bs, 100, "rand_cont", rls);
        check("rand_cont_ready_dropped", rls, 1);

        // Random stream with gaps in valid
        bs = {};
        for (int i = 0; i < 720; i++) bs.push_back(byte'($urandom_range(0, 255)));
        run_poly(bs, 60, "rand_gaps", rls);

        // 48 all-zero words -> 256 zeros
        bs = {};
        for (int i = 0; i < 384; i++) bs.push_back(8'h00);
        run_poly(bs, 100, "zeros", rls);

        // Odd prefix: the last slot meets a triple with two accepts
        bs = {8'hFF, 8'h0F, 8'h00};
        for (int i = 0; i < 389; i++) bs.push_back(8'h00);
        run_poly(bs, 100, "odd", rls);
        check("odd_last_wr_en", last_wr_en, 1);
        if (wr_addr_q.size() > 0) check("odd_last_addr", wr_addr_q[wr_addr_q.size()-1], 255);

        // Restart after about 100 coefficients; stale bytes must not appear
        pulse_start();
        wr_addr_q = {};
        wr_data_q = {};
        budget = 0;
        while (wr_addr_q.size() < 100 && budget < 400) begin
            i_obytes_valid = 1'b1;
            i_obytes       = {$urandom, $urandom};
            @(posedge i_clk); #1;
            budget++;
        end
        i_obytes_valid = 1'b0;
        check("restart_prefix_reached", int'(wr_addr_q.size() >= 100), 1);
        bs = {};
        for (int i = 0; i < 720; i++) bs.push_back(byte'($urandom_range(0, 255)));
        run_poly(bs, 80, "restart", rls);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
